// File: rtl/uart_cmd_decoder_if.sv
// RX FIFO read port seen by the command decoder.
// First-word-fall-through data with a pop strobe back to the FIFO.
interface uart_cmd_decoder_if;
    logic       rx_empty;
    logic [7:0] rx_data;
    logic       rx_pop;

    modport master (
        output rx_empty,
        output rx_data,
        input  rx_pop
    );

    modport slave (
        input  rx_empty,
        input  rx_data,
        output rx_pop
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// UART command decoder: pops RX bytes, matches a command table, pulses.
// Optional macro CMD_CASE_FOLD_EN folds lowercase bytes before matching.
module uart_cmd_decoder #(
    parameter int                   NUM_CMD     = 4,
    parameter logic [8*NUM_CMD-1:0] CMD_CHARS   = {8'h53, 8'h4D, 8'h43, 8'h52},
    parameter int                   MODE        = 0,
    parameter int                   TIMEOUT_CYC = 100_000_000,
    parameter int                   ERR_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_cmd_decoder_if.slave    rx,
    output logic [NUM_CMD-1:0]   cmd_pulse,
    output logic                 cmd_valid,
    output logic [((NUM_CMD > 1) ? $clog2(NUM_CMD) : 1)-1:0] cmd_idx,
    output logic                 pending,
    output logic [ERR_W-1:0]     err_cnt
);

    localparam int IW = (NUM_CMD > 1) ? $clog2(NUM_CMD) : 1;
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

    typedef enum logic {
        IDLE,
        ARMED
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic [NUM_CMD-1:0]   pulse_q, pulse_d;
    logic                 valid_q, valid_d;
    logic [IW-1:0]        cidx_q, cidx_d;
    logic [ERR_W-1:0]     err_q, err_d;

    logic                 pop;
    logic [7:0]           rx_byte;
    logic                 hit;
    logic [IW-1:0]        hit_idx;
    logic                 is_term;
    logic                 emit;
    logic [IW-1:0]        emit_idx;
    logic                 err_inc;

    // Pop whenever the FIFO has data; never while held in reset.
    assign pop       = !rx.rx_empty && !rst;
    assign rx.rx_pop = pop;
    assign is_term   = (rx.rx_data == 8'h0D) || (rx.rx_data == 8'h0A);

    // Optional lowercase fold so 'r' matches an 'R' table entry.
    always_comb begin
        rx_byte = rx.rx_data;
`ifdef CMD_CASE_FOLD_EN
        if (rx_byte >= 8'h61 && rx_byte <= 8'h7A) begin
            rx_byte[5] = 1'b0;
        end
`else
        rx_byte = rx.rx_data;
`endif
    end

    // Parallel table compare; scanning downward lets the lowest index win.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_CMD - 1; i >= 0; i--) begin
            if (rx_byte == CMD_CHARS[8*i +: 8]) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    // Next-state, timer, pulse and error-count decisions.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tmr_d    = tmr_q;
        pulse_d  = '0;
        valid_d  = 1'b0;
        cidx_d   = cidx_q;
        err_d    = err_q;
        emit     = 1'b0;
        emit_idx = idx_q;
        err_inc  = 1'b0;

        if (MODE == 0) begin
            state_d = IDLE;
            tmr_d   = '0;
            if (pop) begin
                if (hit) begin
                    emit     = 1'b1;
                    emit_idx = hit_idx;
                end else if (!is_term) begin
                    err_inc = 1'b1;
                end
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        if (hit) begin
                            idx_d   = hit_idx;
                            tmr_d   = '0;
                            state_d = ARMED;
                        end else if (!is_term) begin
                            err_inc = 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (pop) begin
                        if (is_term) begin
                            emit     = 1'b1;
                            emit_idx = idx_q;
                            state_d  = IDLE;
                        end else if (hit) begin
                            idx_d   = hit_idx;
                            tmr_d   = '0;
                            err_inc = 1'b1;
                        end else begin
                            state_d = IDLE;
                            err_inc = 1'b1;
                        end
                    end else if (tmr_q == TMAX) begin
                        state_d = IDLE;
                        err_inc = 1'b1;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (emit) begin
            valid_d = 1'b1;
            cidx_d  = emit_idx;
            for (int i = 0; i < NUM_CMD; i++) begin
                pulse_d[i] = (emit_idx == IW'(i));
            end
        end

        if (err_inc && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    // State and registered outputs; reset drops any pending command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tmr_q   <= '0;
            pulse_q <= '0;
            valid_q <= 1'b0;
            cidx_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            pulse_q <= pulse_d;
            valid_q <= valid_d;
            cidx_q  <= cidx_d;
            err_q   <= err_d;
        end
    end

    assign cmd_pulse = pulse_q;
    assign cmd_valid = valid_q;
    assign cmd_idx   = cidx_q;
    assign pending   = (state_q == ARMED);
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: three configurations fed one byte stream.
// Directed table, corner sequences and random traffic against a model.
module tb_uart_cmd_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tb_empty = 1'b1;
    logic [7:0] tb_data = 8'h00;

    always #5 clk = ~clk;

    uart_cmd_decoder_if if0 ();
    uart_cmd_decoder_if if1 ();
    uart_cmd_decoder_if if2 ();

    assign if0.rx_empty = tb_empty;
    assign if0.rx_data  = tb_data;
    assign if1.rx_empty = tb_empty;
    assign if1.rx_data  = tb_data;
    assign if2.rx_empty = tb_empty;
    assign if2.rx_data  = tb_data;

    logic [3:0] p0, p1;
    logic [2:0] p2;
    logic       v0, v1, v2;
    logic [1:0] i0, i1, i2;
    logic       pd0, pd1, pd2;
    logic [7:0] e0, e1;
    logic [1:0] e2;

    uart_cmd_decoder u0 (
        .clk(clk), .rst(rst), .rx(if0.slave),
        .cmd_pulse(p0), .cmd_valid(v0), .cmd_idx(i0),
        .pending(pd0), .err_cnt(e0)
    );

    uart_cmd_decoder #(.MODE(1), .TIMEOUT_CYC(50)) u1 (
        .clk(clk), .rst(rst), .rx(if1.slave),
        .cmd_pulse(p1), .cmd_valid(v1), .cmd_idx(i1),
        .pending(pd1), .err_cnt(e1)
    );

    uart_cmd_decoder #(
        .NUM_CMD(3), .CMD_CHARS(24'h414241), .ERR_W(2)
    ) u2 (
        .clk(clk), .rst(rst), .rx(if2.slave),
        .cmd_pulse(p2), .cmd_valid(v2), .cmd_idx(i2),
        .pending(pd2), .err_cnt(e2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: per-configuration rules, tracked as plain integers.
    int         mode [3] = '{0, 1, 0};
    int         tmo  [3] = '{50, 50, 50};
    int         emax [3] = '{255, 255, 3};
    int         ntab [3] = '{4, 4, 3};
    logic [7:0] tab  [3][4] = '{'{8'h52, 8'h43, 8'h4D, 8'h53},
                                '{8'h52, 8'h43, 8'h4D, 8'h53},
                                '{8'h41, 8'h42, 8'h41, 8'h00}};
    int m_pulse [3] = '{0, 0, 0};
    int m_valid [3] = '{0, 0, 0};
    int m_idx   [3] = '{0, 0, 0};
    int m_pend  [3] = '{0, 0, 0};
    int m_err   [3] = '{0, 0, 0};
    bit armed   [3] = '{0, 0, 0};
    int stored  [3] = '{0, 0, 0};
    int age     [3] = '{0, 0, 0};

    function automatic int lookup(int k, logic [7:0] b);
        logic [7:0] c = b;
`ifdef CMD_CASE_FOLD_EN
        if (c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
`endif
        for (int i = 0; i < ntab[k]; i++) begin
            if (tab[k][i] == c) return i;
        end
        return -1;
    endfunction

    task automatic m_emit(int k, int i);
        m_pulse[k] = 1 << i;
        m_valid[k] = 1;
        m_idx[k]   = i;
    endtask

    task automatic m_reset(int k);
        m_pulse[k] = 0; m_valid[k] = 0; m_idx[k] = 0;
        m_pend[k]  = 0; m_err[k]   = 0; armed[k] = 0;
        stored[k]  = 0; age[k]     = 0;
    endtask

    task automatic m_step(int k, bit pop, logic [7:0] b);
        int m;
        bit term;
        bit err = 0;
        m_pulse[k] = 0;
        m_valid[k] = 0;
        m = lookup(k, b);
        term = (b == 8'h0D) || (b == 8'h0A);
        if (pop) begin
            if (mode[k] == 0) begin
                if (m >= 0) m_emit(k, m);
                else if (!term) err = 1;
            end else if (!armed[k]) begin
                if (m >= 0) begin
                    armed[k] = 1; stored[k] = m; age[k] = 0;
                end else if (!term) err = 1;
            end else if (term) begin
                m_emit(k, stored[k]);
                armed[k] = 0;
            end else if (m >= 0) begin
                stored[k] = m; age[k] = 0; err = 1;
            end else begin
                armed[k] = 0; err = 1;
            end
        end else if (mode[k] == 1 && armed[k]) begin
            age[k]++;
            if (age[k] == tmo[k]) begin
                armed[k] = 0; err = 1;
            end
        end
        if (err && m_err[k] < emax[k]) m_err[k]++;
        m_pend[k] = armed[k];
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) m_reset(k);
            else m_step(k, !tb_empty, tb_data);
        end
    end

    task automatic chk_dut(int k, int ap, int av, int ai, int apd, int ae);
        chk($sformatf("u%0d.pulse", k), ap, m_pulse[k]);
        chk($sformatf("u%0d.valid", k), av, m_valid[k]);
        chk($sformatf("u%0d.idx", k), ai, m_idx[k]);
        chk($sformatf("u%0d.pending", k), apd, m_pend[k]);
        chk($sformatf("u%0d.err", k), ae, m_err[k]);
    endtask

    always @(posedge clk) begin
        #1;
        chk_dut(0, int'(p0), int'(v0), int'(i0), int'(pd0), int'(e0));
        chk_dut(1, int'(p1), int'(v1), int'(i1), int'(pd1), int'(e1));
        chk_dut(2, int'(p2), int'(v2), int'(i2), int'(pd2), int'(e2));
    end

    always @(negedge clk) begin
        #2;
        chk("u0.rx_pop", int'(if0.rx_pop), int'(!tb_empty && !rst));
        chk("u1.rx_pop", int'(if1.rx_pop), int'(!tb_empty && !rst));
        chk("u2.rx_pop", int'(if2.rx_pop), int'(!tb_empty && !rst));
    end

    task automatic drive(bit e, logic [7:0] d);
        @(negedge clk);
        tb_empty = e;
        tb_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        tb_empty = 1'b0;
        tb_data  = 8'h52;
        @(posedge clk);
        #1;
        chk("rst.pulse0", int'(p0), 0);
        chk("rst.pend1", int'(pd1), 0);
        chk("rst.err0", int'(e0), 0);
        @(negedge clk);
        rst      = 1'b0;
        tb_empty = 1'b1;
    endtask

    typedef struct {
        bit         e;
        logic [7:0] d;
        logic [3:0] p0;
        int         e0;
        logic [3:0] p1;
        bit         pd1;
        int         e1;
    } vec_t;

    vec_t tv [12];

    int         tcnt;
    int         q_err [5] = '{1, 2, 3, 3, 3};
    logic [7:0] pick  [10] = '{8'h52, 8'h43, 8'h4D, 8'h53, 8'h0D,
                               8'h0A, 8'h72, 8'h41, 8'h42, 8'h61};

    initial begin
        tv[0]  = '{0, 8'h52, 4'b0001, 0, 4'b0000, 1, 0};
        tv[1]  = '{0, 8'h43, 4'b0010, 0, 4'b0000, 1, 1};
        tv[2]  = '{0, 8'h4D, 4'b0100, 0, 4'b0000, 1, 2};
        tv[3]  = '{0, 8'h53, 4'b1000, 0, 4'b0000, 1, 3};
        tv[4]  = '{0, 8'h0D, 4'b0000, 0, 4'b1000, 0, 3};
        tv[5]  = '{0, 8'h58, 4'b0000, 1, 4'b0000, 0, 4};
        tv[6]  = '{0, 8'h0D, 4'b0000, 1, 4'b0000, 0, 4};
        tv[7]  = '{0, 8'h5A, 4'b0000, 2, 4'b0000, 0, 5};
        tv[8]  = '{0, 8'h4D, 4'b0100, 2, 4'b0000, 1, 5};
        tv[9]  = '{0, 8'h0D, 4'b0000, 2, 4'b0100, 0, 5};
        tv[10] = '{0, 8'h0A, 4'b0000, 2, 4'b0000, 0, 5};
        tv[11] = '{1, 8'h00, 4'b0000, 2, 4'b0000, 0, 5};

        repeat (2) @(posedge clk);
        #1;
        chk("init.err1", int'(e1), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(tv[i].e, tv[i].d);
            chk($sformatf("tv%0d.p0", i), int'(p0), int'(tv[i].p0));
            chk($sformatf("tv%0d.e0", i), int'(e0), tv[i].e0);
            chk($sformatf("tv%0d.p1", i), int'(p1), int'(tv[i].p1));
            chk($sformatf("tv%0d.pd1", i), int'(pd1), int'(tv[i].pd1));
            chk($sformatf("tv%0d.e1", i), int'(e1), tv[i].e1);
        end
        chk("tv.idx1", int'(i1), 2);

        do_reset();
        drive(0, 8'h53);
        chk("tmo.pend", int'(pd1), 1);
        tcnt = 1;
        for (int c = 0; c < 200; c++) begin
            drive(1, 8'h00);
            if (v1) chk("tmo.nopulse", int'(v1), 0);
            if (!pd1) break;
            tcnt++;
        end
        chk("tmo.len", tcnt, 50);
        chk("tmo.err", int'(e1), 1);
        drive(0, 8'h43);
        drive(0, 8'h0D);
        chk("tmo.next", int'(p1), 4'b0010);

        do_reset();
        drive(0, 8'h53);
        repeat (49) drive(1, 8'h00);
        chk("edge.pend", int'(pd1), 1);
        drive(0, 8'h0D);
        chk("edge.pulse", int'(p1), 4'b1000);
        chk("edge.err", int'(e1), 0);

        do_reset();
        drive(0, 8'h52);
        chk("rstmid.pend", int'(pd1), 1);
        do_reset();
        drive(0, 8'h0D);
        chk("rstmid.pulse", int'(p1), 0);
        chk("rstmid.pend2", int'(pd1), 0);
        chk("rstmid.err", int'(e1), 0);

        do_reset();
        drive(0, 8'h41);
        chk("dup.pulse", int'(p2), 3'b001);
        chk("dup.idx", int'(i2), 0);
        drive(0, 8'h42);
        chk("dup.pulseB", int'(p2), 3'b010);
        drive(1, 8'h00);
        chk("hold.idx", int'(i2), 1);
        chk("hold.valid", int'(v2), 0);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 8'h51);
            chk($sformatf("sat.err%0d", i), int'(e2), q_err[i]);
        end

        do_reset();
`ifdef CMD_CASE_FOLD_EN
        drive(0, 8'h72);
        chk("fold.p0", int'(p0), 4'b0001);
        drive(0, 8'h0D);
        chk("fold.p1", int'(p1), 4'b0001);
`else
        drive(0, 8'h72);
        chk("nofold.p0", int'(p0), 0);
        chk("nofold.e0", int'(e0), 1);
`endif

        do_reset();
        for (int seg = 0; seg < 8; seg++) begin
            int pe;
            pe = (seg % 2 == 1) ? 98 : 40;
            for (int c = 0; c < 400; c++) begin
                bit e;
                logic [7:0] d;
                e = ($urandom_range(99) < pe);
                if ($urandom_range(9) == 0) d = 8'($urandom);
                else d = pick[$urandom_range(9)];
                drive(e, d);
            end
            if (seg == 4) do_reset();
        end
        repeat (3) drive(1, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
